// File: rtl/zeroskip_pkg.sv
// ============================================================================
// Module      : zeroskip_pkg
// Description : Shared types, constants and helpers for the zeroskip scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zeroskip_pkg;

  localparam int C_GROUP_NZ_MAX = 16;
  localparam int LIMIT_8_32     = 8;

  typedef enum logic [0:0] {
    MODE_8_32  = 1'b0,
    MODE_16_32 = 1'b1
  } mode_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic [$clog2(C_GROUP_NZ_MAX):0] nnz_t;

  // Clamp a raw popcount to the active sparsity limit.
  function automatic nnz_t sat_nnz(input logic [7:0] cnt, input nnz_t limit);
    if (cnt > 8'(limit)) return limit;
    return nnz_t'(cnt);
  endfunction

endpackage

`default_nettype wire

// File: rtl/zeroskip_sched_compactor.sv
// ============================================================================
// Module      : zeroskip_sched_compactor
// Description : Combinational zeroskip; packs masked elements toward slot 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zeroskip_sched_compactor
  import zeroskip_pkg::*;
#(
  parameter int GROUP_SIZE   = 32,
  parameter int GROUP_NZ_MAX = 16,
  parameter int DATA_W       = 8
) (
  input  logic [GROUP_SIZE-1:0]          in_mask,
  input  logic [GROUP_SIZE*DATA_W-1:0]   in_data,
  output logic [GROUP_NZ_MAX*DATA_W-1:0] comp_data,
  output logic [$clog2(GROUP_SIZE):0]    comp_cnt
);

  localparam int CW = $clog2(GROUP_SIZE) + 1;

  // Slots past GROUP_NZ_MAX-1 have no write enable, so extra nonzeros fall away.
  always_comb begin : p_compact
    int cnt;
    comp_data = '0;
    cnt       = 0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (in_mask[i]) begin
        for (int j = 0; j < GROUP_NZ_MAX; j++) begin
          if (cnt == j) comp_data[j*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
        end
        cnt = cnt + 1;
      end
    end
    comp_cnt = CW'(cnt);
  end

endmodule

`default_nettype wire

// File: rtl/zeroskip_sched.sv
// ============================================================================
// Module      : zeroskip_sched
// Description : Group scheduler: compacts one dense group per handshake and
//               streams its nonzeros in OUT_LANES-wide beats.
//               Optional macro ZEROSKIP_SCHED_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zeroskip_sched
  import zeroskip_pkg::*;
#(
  parameter int GROUP_SIZE   = 32,
  parameter int GROUP_NZ_MAX = C_GROUP_NZ_MAX,
  parameter int DATA_W       = 8,
  parameter int OUT_LANES    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [GROUP_SIZE-1:0]          in_mask,
  input  logic [GROUP_SIZE*DATA_W-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_LANES*DATA_W-1:0]    out_data,
  output logic [OUT_LANES-1:0]           out_lane_vld,
  output logic                           out_last,
  output logic [$clog2(GROUP_NZ_MAX):0]  out_grp_nnz,
  output logic                           err_overflow,
  input  logic                           err_clr
`ifdef ZEROSKIP_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_grp_cnt,
  output logic [31:0]                    perf_nz_cnt,
  output logic [31:0]                    perf_stall_cnt
`endif
);

  localparam int BEAT_W    = OUT_LANES * DATA_W;
  localparam int BEATS_MAX = GROUP_NZ_MAX / OUT_LANES;
  localparam int PW        = $clog2(BEATS_MAX) + 1;
  localparam int BUF_W     = GROUP_NZ_MAX * DATA_W;

  state_e                    r_state;
  logic [BUF_W-1:0]          r_buf;
  logic [PW-1:0]             r_ptr;
  nnz_t                      r_nnz;

  logic [BUF_W-1:0]          w_comp_data;
  logic [$clog2(GROUP_SIZE):0] w_comp_cnt;
  nnz_t                      w_limit;
  nnz_t                      w_nnz_eff;
  logic                      w_overflow;
  logic [BUF_W-1:0]          w_new_buf;
  logic [OUT_LANES-1:0]      w_new_lane;
  logic                      w_new_last;
  logic [PW-1:0]             w_next_ptr;
  logic [BEAT_W-1:0]         w_next_beat;
  logic [OUT_LANES-1:0]      w_next_lane;
  logic                      w_next_last;
  logic                      w_accept;
  logic                      w_fire;

  zeroskip_sched_compactor #(
    .GROUP_SIZE   (GROUP_SIZE),
    .GROUP_NZ_MAX (GROUP_NZ_MAX),
    .DATA_W       (DATA_W)
  ) u_compactor (
    .in_mask   (in_mask),
    .in_data   (in_data),
    .comp_data (w_comp_data),
    .comp_cnt  (w_comp_cnt)
  );

  assign in_ready = (r_state == IDLE) || (out_ready && out_last);
  assign w_accept = in_valid && in_ready;
  assign w_fire   = out_valid && out_ready;

  // Incoming group: apply the mode limit and build beat 0 straight from it.
  always_comb begin : p_load
    w_limit    = (mode_e'(cfg_mode) == MODE_16_32) ? nnz_t'(GROUP_NZ_MAX) : nnz_t'(LIMIT_8_32);
    w_nnz_eff  = sat_nnz(8'(w_comp_cnt), w_limit);
    w_overflow = 8'(w_comp_cnt) > 8'(w_limit);
    w_new_buf  = '0;
    for (int j = 0; j < GROUP_NZ_MAX; j++) begin
      if (j < int'(w_nnz_eff)) w_new_buf[j*DATA_W +: DATA_W] = w_comp_data[j*DATA_W +: DATA_W];
    end
    for (int l = 0; l < OUT_LANES; l++) w_new_lane[l] = l < int'(w_nnz_eff);
    w_new_last = int'(w_nnz_eff) <= OUT_LANES;
  end

  always_comb begin : p_next
    w_next_ptr  = r_ptr + 1'b1;
    w_next_beat = '0;
    for (int b = 0; b < BEATS_MAX; b++) begin
      if (int'(w_next_ptr) == b) w_next_beat = r_buf[b*BEAT_W +: BEAT_W];
    end
    for (int l = 0; l < OUT_LANES; l++) begin
      w_next_lane[l] = (int'(w_next_ptr) * OUT_LANES + l) < int'(r_nnz);
    end
    w_next_last = (int'(w_next_ptr) + 1) * OUT_LANES >= int'(r_nnz);
  end

  always_ff @(posedge clk) begin : p_fsm
    if (rst) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_ptr        <= '0;
      r_nnz        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_lane_vld <= '0;
      out_last     <= 1'b0;
      out_grp_nnz  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state      <= EMIT;
        r_buf        <= w_new_buf;
        r_ptr        <= '0;
        r_nnz        <= w_nnz_eff;
        out_valid    <= 1'b1;
        out_data     <= w_new_buf[BEAT_W-1:0];
        out_lane_vld <= w_new_lane;
        out_last     <= w_new_last;
        out_grp_nnz  <= w_nnz_eff;
      end else if (w_fire) begin
        if (out_last) begin
          r_state      <= IDLE;
          r_ptr        <= '0;
          out_valid    <= 1'b0;
          out_data     <= '0;
          out_lane_vld <= '0;
          out_last     <= 1'b0;
          out_grp_nnz  <= '0;
        end else begin
          r_ptr        <= w_next_ptr;
          out_data     <= w_next_beat;
          out_lane_vld <= w_next_lane;
          out_last     <= w_next_last;
        end
      end

      if (w_accept && w_overflow) err_overflow <= 1'b1;
      else if (err_clr)           err_overflow <= 1'b0;
    end
  end

`ifdef ZEROSKIP_SCHED_PERF_EN
  always_ff @(posedge clk) begin : p_perf
    if (rst) begin
      perf_grp_cnt   <= '0;
      perf_nz_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        perf_grp_cnt <= perf_grp_cnt + 32'd1;
        perf_nz_cnt  <= perf_nz_cnt + 32'(w_nnz_eff);
      end
      if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_zeroskip_sched.sv
// ============================================================================
// Module      : tb_zeroskip_sched
// Description : Directed and scoreboarded bench for zeroskip_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zeroskip_sched;

  localparam int GS = 32;
  localparam int NZ = 16;
  localparam int DW = 8;
  localparam int OL = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  lane;
    logic        last;
    logic [4:0]  nnz;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          cfg_mode;
  logic          in_valid;
  logic          in_ready;
  logic [GS-1:0] in_mask;
  logic [GS*DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OL*DW-1:0] out_data;
  logic [OL-1:0] out_lane_vld;
  logic          out_last;
  logic [4:0]    out_grp_nnz;
  logic          err_overflow;
  logic          err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t exp_q[$];

  zeroskip_sched #(
    .GROUP_SIZE(GS), .GROUP_NZ_MAX(NZ), .DATA_W(DW), .OUT_LANES(OL)
  ) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_vld(out_lane_vld), .out_last(out_last), .out_grp_nnz(out_grp_nnz),
    .err_overflow(err_overflow), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < GS; i++) in_data[i*DW +: DW] = 8'(i + 1);
  endtask

  function automatic logic [31:0] ramp_beat(input int first);
    logic [31:0] r;
    for (int l = 0; l < OL; l++) r[l*8 +: 8] = 8'(first + l);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1; cfg_mode = 0; in_valid = 0; in_mask = '0; in_data = '0;
    out_ready = 0; err_clr = 0;
    tick(); tick();
    rst = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_checks++; if (out_lane_vld !== 4'h0) begin n_fail++; $display("FAIL reset_lane_vld got %h want 0", out_lane_vld); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_grp_nnz !== 5'd0) begin n_fail++; $display("FAIL reset_grp_nnz got %0d want 0", out_grp_nnz); end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_overflow); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_mode16_dense();
    cfg_mode = 1; in_mask = 32'h0000_FFFF; set_ramp(); out_ready = 1; in_valid = 1;
    tick();
    in_valid = 0;
    for (int b = 0; b < 4; b++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL m16_valid b%0d got %b want 1", b, out_valid); end
      n_checks++; if (out_data !== ramp_beat(4*b + 1)) begin n_fail++; $display("FAIL m16_data b%0d got %h want %h", b, out_data, ramp_beat(4*b + 1)); end
      n_checks++; if (out_lane_vld !== 4'hF) begin n_fail++; $display("FAIL m16_lane b%0d got %h want f", b, out_lane_vld); end
      n_checks++; if (out_last !== (b == 3)) begin n_fail++; $display("FAIL m16_last b%0d got %b want %b", b, out_last, b == 3); end
      n_checks++; if (out_grp_nnz !== 5'd16) begin n_fail++; $display("FAIL m16_nnz b%0d got %0d want 16", b, out_grp_nnz); end
      n_checks++; if (in_ready !== (b == 3)) begin n_fail++; $display("FAIL m16_in_ready b%0d got %b want %b", b, in_ready, b == 3); end
      n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL m16_err b%0d got %b want 0", b, err_overflow); end
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL m16_idle got %b want 0", out_valid); end
  endtask

  task automatic test_mode8_overflow();
    cfg_mode = 0; in_mask = 32'hFFFF_FFFF; set_ramp(); out_ready = 1; in_valid = 1;
    err_clr = 1;
    tick();
    in_valid = 0; err_clr = 0; cfg_mode = 1;
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL m8_err_set got %b want 1", err_overflow); end
    for (int b = 0; b < 2; b++) begin
      n_checks++; if (out_data !== ramp_beat(4*b + 1)) begin n_fail++; $display("FAIL m8_data b%0d got %h want %h", b, out_data, ramp_beat(4*b + 1)); end
      n_checks++; if (out_lane_vld !== 4'hF) begin n_fail++; $display("FAIL m8_lane b%0d got %h want f", b, out_lane_vld); end
      n_checks++; if (out_last !== (b == 1)) begin n_fail++; $display("FAIL m8_last b%0d got %b want %b", b, out_last, b == 1); end
      n_checks++; if (out_grp_nnz !== 5'd8) begin n_fail++; $display("FAIL m8_nnz b%0d got %0d want 8", b, out_grp_nnz); end
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL m8_idle got %b want 0", out_valid); end
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL m8_err_sticky got %b want 1", err_overflow); end
    err_clr = 1;
    tick();
    err_clr = 0;
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL m8_err_clr got %b want 0", err_overflow); end
  endtask

  task automatic test_zero_then_sparse();
    cfg_mode = 1; in_mask = 32'h0; set_ramp(); out_ready = 1; in_valid = 1;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %b want 1", out_valid); end
    n_checks++; if (out_lane_vld !== 4'h0) begin n_fail++; $display("FAIL zero_lane got %h want 0", out_lane_vld); end
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL zero_last got %b want 1", out_last); end
    n_checks++; if (out_grp_nnz !== 5'd0) begin n_fail++; $display("FAIL zero_nnz got %0d want 0", out_grp_nnz); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL zero_data got %h want 0", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_in_ready got %b want 1", in_ready); end
    in_mask = 32'h8000_0021;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sparse_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 32'h0020_0601) begin n_fail++; $display("FAIL sparse_data got %h want 00200601", out_data); end
    n_checks++; if (out_lane_vld !== 4'h7) begin n_fail++; $display("FAIL sparse_lane got %h want 7", out_lane_vld); end
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL sparse_last got %b want 1", out_last); end
    n_checks++; if (out_grp_nnz !== 5'd3) begin n_fail++; $display("FAIL sparse_nnz got %0d want 3", out_grp_nnz); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sparse_idle got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int g, cycles, k, lim, nb, p;
    bit pending, any_ovf, was_stall;
    logic [31:0] s_data, g_mask;
    logic [3:0]  s_lane;
    logic        s_last, g_mode;
    logic [4:0]  s_nnz;
    logic [GS*DW-1:0] g_data;
    int idx[$];
    beat_t eb;
    g = 0; cycles = 0; pending = 0; any_ovf = 0; was_stall = 0;
    g_mask = '0; g_mode = 0; g_data = '0;
    s_data = '0; s_lane = '0; s_last = 0; s_nnz = '0;
    err_clr = 0;
    while ((g < 100 || pending || exp_q.size() != 0 || out_valid) && cycles < 20000) begin
      if (!pending && g < 100) begin
        case ($urandom_range(0, 3))
          0:       g_mask = 32'h0;
          1:       g_mask = 32'hFFFF_FFFF;
          2:       g_mask = $urandom();
          default: g_mask = $urandom() & $urandom() & $urandom();
        endcase
        g_mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < GS; i++) g_data[i*DW +: DW] = 8'($urandom_range(1, 255));
        pending = 1;
      end
      in_valid = pending; in_mask = g_mask; in_data = g_data; cfg_mode = g_mode;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (was_stall) begin
        n_checks++; if (out_data !== s_data) begin n_fail++; $display("FAIL b2b_stall_data got %h want %h", out_data, s_data); end
        n_checks++; if (out_lane_vld !== s_lane) begin n_fail++; $display("FAIL b2b_stall_lane got %h want %h", out_lane_vld, s_lane); end
        n_checks++; if (out_last !== s_last) begin n_fail++; $display("FAIL b2b_stall_last got %b want %b", out_last, s_last); end
        n_checks++; if (out_grp_nnz !== s_nnz) begin n_fail++; $display("FAIL b2b_stall_nnz got %0d want %0d", out_grp_nnz, s_nnz); end
      end
      n_checks++;
      if (in_ready !== (!out_valid || (out_ready && out_last))) begin
        n_fail++; $display("FAIL b2b_in_ready got %b want %b", in_ready, !out_valid || (out_ready && out_last));
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_beat got data %h want no beat", out_data);
        end else begin
          eb = exp_q.pop_front();
          if (out_data !== eb.data || out_lane_vld !== eb.lane || out_last !== eb.last || out_grp_nnz !== eb.nnz) begin
            n_fail++;
            $display("FAIL b2b_beat got d=%h l=%h last=%b n=%0d want d=%h l=%h last=%b n=%0d",
                     out_data, out_lane_vld, out_last, out_grp_nnz, eb.data, eb.lane, eb.last, eb.nnz);
          end
        end
      end
      if (in_valid && in_ready) begin
        idx.delete();
        for (int i = 0; i < GS; i++) if (g_mask[i]) idx.push_back(i);
        lim = g_mode ? 16 : 8;
        if (idx.size() > lim) any_ovf = 1;
        k  = (idx.size() > lim) ? lim : idx.size();
        nb = (k == 0) ? 1 : (k + 3) / 4;
        for (int b = 0; b < nb; b++) begin
          eb = '0;
          for (int l = 0; l < OL; l++) begin
            p = b*4 + l;
            if (p < k) begin
              eb.data[l*8 +: 8] = g_data[idx[p]*DW +: DW];
              eb.lane[l] = 1'b1;
            end
          end
          eb.last = (b == nb - 1);
          eb.nnz  = 5'(k);
          exp_q.push_back(eb);
        end
        pending = 0;
        g++;
      end
      was_stall = out_valid && !out_ready;
      s_data = out_data; s_lane = out_lane_vld; s_last = out_last; s_nnz = out_grp_nnz;
      tick();
      cycles++;
    end
    in_valid = 0;
    n_checks++;
    if (cycles >= 20000 || g != 100 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_complete got groups=%0d pending_beats=%0d want groups=100 pending_beats=0", g, exp_q.size());
    end
    n_checks++; if (err_overflow !== any_ovf) begin n_fail++; $display("FAIL b2b_err got %b want %b", err_overflow, any_ovf); end
  endtask

  task automatic test_rst_mid_emit();
    cfg_mode = 1; in_mask = 32'h0000_FFFF; set_ramp(); out_ready = 1; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    n_checks++; if (out_data !== ramp_beat(5)) begin n_fail++; $display("FAIL rst_beat2_data got %h want %h", out_data, ramp_beat(5)); end
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0 || out_lane_vld !== 4'h0 || out_last !== 1'b0 || out_grp_nnz !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid_outs got d=%h l=%h last=%b n=%0d want all 0", out_data, out_lane_vld, out_last, out_grp_nnz);
    end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got %b want 0", err_overflow); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle got in_ready %b want 1", in_ready); end
    in_mask = 32'h0000_00F0; in_valid = 1;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== ramp_beat(5)) begin
      n_fail++; $display("FAIL rst_after_data got v=%b d=%h want v=1 d=%h", out_valid, out_data, ramp_beat(5));
    end
    n_checks++; if (out_lane_vld !== 4'hF || out_last !== 1'b1 || out_grp_nnz !== 5'd4) begin
      n_fail++; $display("FAIL rst_after_ctl got l=%h last=%b n=%0d want l=f last=1 n=4", out_lane_vld, out_last, out_grp_nnz);
    end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_idle got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_mode16_dense();
    test_mode8_overflow();
    test_zero_then_sparse();
    test_back_to_back();
    test_rst_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zeroskip_sched.md
Name: zeroskip_sched

Overview:
Group scheduler for the zeroskip compactor. It accepts one dense activation group per handshake and compacts it through a zeroskip instance into a register buffer. It then streams the nonzeros downstream in OUT_LANES-wide beats with valid/ready. Runtime cfg_mode selects 8:32 or 16:32 sparsity; groups exceeding the mode limit are truncated and flagged. Sits between the activation fetch unit and the sparse MAC array feeder.

Parameters:
GROUP_SIZE, 32, dense activations per group
GROUP_NZ_MAX, 16, max nonzeros kept per group (16:32 limit)
DATA_W, 8, activation width
OUT_LANES, 4, activations per output beat; must divide GROUP_NZ_MAX

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_mode  in  1  0 = 8:32 (limit 8), 1 = 16:32 (limit GROUP_NZ_MAX); sampled only at group accept
in_valid  in  1  group offered
in_ready  out  1  group accepted when in_valid && in_ready
in_mask  in  GROUP_SIZE  1 = element nonzero
in_data  in  GROUP_SIZE*DATA_W  dense activations
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
out_data  out  OUT_LANES*DATA_W  compacted activations, lane 0 = lowest index
out_lane_vld  out  OUT_LANES  per-lane valid, contiguous from lane 0
out_last  out  1  final beat of group
out_grp_nnz  out  $clog2(GROUP_NZ_MAX)+1  effective nonzero count of current group, stable for all its beats
err_overflow  out  1  sticky: some group exceeded mode limit
err_clr  in  1  clears err_overflow

Behaviour:
- Reset values: state IDLE, out_valid 0, out_last 0, out_lane_vld 0, out_data 0, out_grp_nnz 0, err_overflow 0, beat pointer 0, buffer 0.
- FSM states are IDLE and EMIT.
  - IDLE: in_ready = 1. On accept, latch compactor output, nnz_eff and mode limit, then go to EMIT.
  - EMIT: out_valid = 1. Beat b carries buffer entries b*OUT_LANES .. b*OUT_LANES+OUT_LANES-1. The beat pointer advances only on out_valid && out_ready.
- Beat count = ceil(nnz_eff/OUT_LANES). If nnz_eff = 0, exactly one beat is emitted with out_lane_vld = 0 and out_last = 1, so group alignment is preserved.
- Latency: group accepted at edge N → first beat valid after edge N (visible in cycle N+1). Zero bubble between groups.
- in_ready in EMIT = out_ready && out_last.
  - If a new group is accepted on the same edge the last beat retires, stay in EMIT with the new buffer and reset the pointer to 0.
  - Otherwise the last-beat retirement returns to IDLE.
- nnz = popcount(in_mask). limit = 8 if cfg_mode = 0, else GROUP_NZ_MAX. nnz_eff = min(nnz, limit).
  - Entries at or beyond limit are discarded.
  - Buffer slots ≥ nnz_eff read as 0, and out_lane_vld for those slots is 0.
- err_overflow is set on accept when nnz > limit.
  - err_clr and a set on the same edge: set wins.
  - err_clr in other cycles clears the flag.
- cfg_mode changes while in EMIT do not affect the group in flight.
- out_data, out_lane_vld, out_last and out_grp_nnz are held stable while out_valid && !out_ready.
- rst mid-EMIT: the buffered group is dropped; all outputs return to reset values on the next edge.
- Compactor: combinational zeroskip on in_data/in_mask. Write enables for compactor outputs beyond GROUP_NZ_MAX-1 are suppressed; the index never aliases.

Optional Feature:
ZEROSKIP_SCHED_PERF_EN:
- When defined, adds three 32-bit wrap-around counters as outputs, all cleared by rst:
  - perf_grp_cnt: groups accepted
  - perf_nz_cnt: nnz_eff summed
  - perf_stall_cnt: cycles with out_valid && !out_ready
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- zeroskip_pkg holds:
  - mode_e (MODE_8_32, MODE_16_32)
  - state_e (IDLE, EMIT)
  - nnz_t sized $clog2(GROUP_NZ_MAX)+1
  - constant LIMIT_8_32 = 8
  - function for popcount saturation
- Sub-module: the existing zeroskip compactor, instantiated once. Beat slicing and the FSM stay in zeroskip_sched.

Test Plan:
- Mode 1, mask 0x0000_FFFF, data[i] = i+1, out_ready = 1 → 4 beats: {1,2,3,4} .. {13,14,15,16}; lane_vld 0xF each; last on beat 4; nnz 16; err 0.
- Mode 0, mask 0xFFFF_FFFF → 2 beats, data 1..8, out_grp_nnz 8, err_overflow = 1 one cycle after accept; err_clr pulse → 0.
- Mask 0 → one beat, lane_vld 0, last 1, nnz 0; next group is accepted on the same edge.
- Mask 0x8000_0021, mode 1 → one beat {data0, data5, data31, 0}, lane_vld 0x7, last 1.
- Back-to-back groups with out_ready toggled 1/0 → outputs stable during stalls; in_ready only on the retiring last beat; no lost or duplicated beats over 100 random groups (scoreboard vs model).
- rst asserted during beat 2 of a 4-beat group → next cycle out_valid 0, state IDLE, err 0; a subsequent group streams correctly.
